// File: rtl/serial_link_vc_axis_rx.sv
// serial_link_vc_axis_rx
//   Receive side of the virtual-channel credit link. Incoming AXIS packets carry
//   tdata = {vc_idx, payload} and tuser = {data_validity, credits}.
//   - Payloads are split into per-VC FIFOs of depth NumCredits.
//   - Piggybacked credits are forwarded to the local transmitter as a 1-cycle pulse.
//   - Freed queue slots are accumulated in credits_pending_o until the local
//     transmitter takes them.
//
// Ports
//   clk_i, rst_ni           clock, synchronous active-low reset
//   axis_t*                 incoming packet stream (tready is combinational)
//   vc_valid_o/ready_i/data_o   per-VC output streams
//   credits_rcvd_valid_o/_o     credits received from the far end, per VC
//   credits_pending_o           freed slots not yet returned, per VC
//   credits_taken_i             local TX consumed credits_pending_o this cycle
//   force_send_o                pending count reached ForceSendThresh
//   err_o                       sticky: bad vc_idx or pending-credit overflow
//   stat_flits_o                per-VC pushed data-flit count
//
// Configuration
//   SERIAL_LINK_VC_RX_STATS_EN  defined: 16-bit wrapping per-VC push counters drive
//                               stat_flits_o. Undefined: stat_flits_o tied to 0.

module serial_link_vc_axis_rx #(
    parameter int unsigned NumVc           = 2,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned NumCredits      = 6,
    parameter int unsigned ForceSendThresh = NumCredits - 4,
    localparam int unsigned CreditW        = $clog2(NumCredits + 1),
    localparam int unsigned VcIdxW         = $clog2(NumVc)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              axis_tvalid_i,
    output logic                              axis_tready_o,
    input  logic [VcIdxW+DataWidth-1:0]       axis_tdata_i,
    input  logic [CreditW:0]                  axis_tuser_i,
    output logic [NumVc-1:0]                  vc_valid_o,
    input  logic [NumVc-1:0]                  vc_ready_i,
    output logic [NumVc-1:0][DataWidth-1:0]   vc_data_o,
    output logic [NumVc-1:0]                  credits_rcvd_valid_o,
    output logic [NumVc-1:0][CreditW-1:0]     credits_rcvd_o,
    output logic [NumVc-1:0][CreditW-1:0]     credits_pending_o,
    input  logic [NumVc-1:0]                  credits_taken_i,
    output logic [NumVc-1:0]                  force_send_o,
    output logic                              err_o,
    output logic [NumVc-1:0][15:0]            stat_flits_o
);

    localparam int unsigned PtrW = (NumCredits > 1) ? $clog2(NumCredits) : 1;
    localparam logic [CreditW-1:0] MaxCnt  = CreditW'(NumCredits);
    localparam logic [CreditW-1:0] Thresh  = CreditW'(ForceSendThresh);
    localparam logic [PtrW-1:0]    LastPtr = PtrW'(NumCredits - 1);

    // Packet field split
    logic [VcIdxW-1:0]    w_vc_idx;
    logic [DataWidth-1:0] w_payload;
    logic                 w_validity;
    logic [CreditW-1:0]   w_credits;
    logic                 w_idx_ok;

    assign {w_vc_idx, w_payload}   = axis_tdata_i;
    assign {w_validity, w_credits} = axis_tuser_i;
    assign w_idx_ok                = (32'(w_vc_idx) < NumVc);

    // Per-VC state
    logic [DataWidth-1:0]          r_mem [NumVc][NumCredits];
    logic [NumVc-1:0][PtrW-1:0]    r_wptr;
    logic [NumVc-1:0][PtrW-1:0]    r_rptr;
    logic [NumVc-1:0][CreditW-1:0] r_cnt;
    logic [NumVc-1:0][CreditW-1:0] r_pending;
    logic [NumVc-1:0]              r_crd_valid;
    logic [NumVc-1:0][CreditW-1:0] r_crd_val;
    logic                          r_err;

    // Decode
    logic [NumVc-1:0]              w_sel;
    logic [NumVc-1:0]              w_full;
    logic                          w_sel_full;
    logic                          w_hs;
    logic [NumVc-1:0]              w_push;
    logic [NumVc-1:0]              w_pop;
    logic [NumVc-1:0][CreditW-1:0] w_pend_base;
    logic [NumVc-1:0][CreditW-1:0] w_pend_d;
    logic [NumVc-1:0]              w_pend_ovf;

    always_comb begin
        w_sel      = '0;
        w_full     = '0;
        w_sel_full = 1'b0;
        for (int v = 0; v < NumVc; v++) begin
            w_sel[v]  = w_idx_ok && (w_vc_idx == VcIdxW'(v));
            w_full[v] = (r_cnt[v] == MaxCnt);
            if (w_sel[v] && w_full[v]) begin
                w_sel_full = 1'b1;
            end
        end
    end

    // Full state is taken before any same-cycle pop, so a full queue never
    // accepts even while it drains.
    assign axis_tready_o = !w_validity || !w_idx_ok || !w_sel_full;
    assign w_hs          = axis_tvalid_i && axis_tready_o;
    assign w_push        = {NumVc{w_hs && w_validity}} & w_sel;
    assign w_pop         = vc_valid_o & vc_ready_i;

    // Pending-return counter: a take clears the old count, a same-cycle pop
    // still counts against the cleared value.
    always_comb begin
        w_pend_base = '0;
        w_pend_d    = '0;
        w_pend_ovf  = '0;
        for (int v = 0; v < NumVc; v++) begin
            w_pend_base[v] = credits_taken_i[v] ? '0 : r_pending[v];
            w_pend_d[v]    = w_pend_base[v];
            if (w_pop[v]) begin
                if (w_pend_base[v] == MaxCnt) begin
                    w_pend_ovf[v] = 1'b1;
                end else begin
                    w_pend_d[v] = w_pend_base[v] + 1'b1;
                end
            end
        end
    end

    // Queue storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        for (int v = 0; v < NumVc; v++) begin
            if (w_push[v]) begin
                r_mem[v][r_wptr[v]] <= w_payload;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_pending   <= '0;
            r_crd_valid <= '0;
            r_crd_val   <= '0;
            r_err       <= 1'b0;
        end else begin
            for (int v = 0; v < NumVc; v++) begin
                if (w_push[v]) begin
                    r_wptr[v] <= (r_wptr[v] == LastPtr) ? '0 : r_wptr[v] + 1'b1;
                end
                if (w_pop[v]) begin
                    r_rptr[v] <= (r_rptr[v] == LastPtr) ? '0 : r_rptr[v] + 1'b1;
                end
                case ({w_push[v], w_pop[v]})
                    2'b10:   r_cnt[v] <= r_cnt[v] + 1'b1;
                    2'b01:   r_cnt[v] <= r_cnt[v] - 1'b1;
                    default: r_cnt[v] <= r_cnt[v];
                endcase
                r_pending[v] <= w_pend_d[v];

                // Credit pulse lasts exactly one cycle; value is zero otherwise.
                if (w_hs && w_sel[v] && (w_credits != '0)) begin
                    r_crd_valid[v] <= 1'b1;
                    r_crd_val[v]   <= w_credits;
                end else begin
                    r_crd_valid[v] <= 1'b0;
                    r_crd_val[v]   <= '0;
                end
            end
            if ((w_hs && !w_idx_ok) || (w_pend_ovf != '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        vc_valid_o   = '0;
        vc_data_o    = '0;
        force_send_o = '0;
        for (int v = 0; v < NumVc; v++) begin
            vc_valid_o[v]   = (r_cnt[v] != '0);
            vc_data_o[v]    = r_mem[v][r_rptr[v]];
            force_send_o[v] = (r_pending[v] >= Thresh);
        end
    end

    assign credits_rcvd_valid_o = r_crd_valid;
    assign credits_rcvd_o       = r_crd_val;
    assign credits_pending_o    = r_pending;
    assign err_o                = r_err;

`ifdef SERIAL_LINK_VC_RX_STATS_EN
    logic [NumVc-1:0][15:0] r_stat;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stat <= '0;
        end else begin
            for (int v = 0; v < NumVc; v++) begin
                if (w_push[v]) begin
                    r_stat[v] <= r_stat[v] + 16'd1;
                end
            end
        end
    end

    assign stat_flits_o = r_stat;
`else
    assign stat_flits_o = '0;
`endif

endmodule

// File: tb/tb_serial_link_vc_axis_rx.sv
module tb_serial_link_vc_axis_rx;

    localparam int unsigned NumVc      = 3;
    localparam int unsigned DataWidth  = 32;
    localparam int unsigned NumCredits = 6;
    localparam int unsigned CreditW    = 3;
    localparam int unsigned VcIdxW     = 2;

    logic                              clk = 1'b0;
    logic                              rst_ni;
    logic                              tvalid;
    logic                              tready;
    logic [VcIdxW+DataWidth-1:0]       tdata;
    logic [CreditW:0]                  tuser;
    logic [NumVc-1:0]                  vc_valid;
    logic [NumVc-1:0]                  vc_ready;
    logic [NumVc-1:0][DataWidth-1:0]   vc_data;
    logic [NumVc-1:0]                  crd_valid;
    logic [NumVc-1:0][CreditW-1:0]     crd_rcvd;
    logic [NumVc-1:0][CreditW-1:0]     crd_pend;
    logic [NumVc-1:0]                  taken;
    logic [NumVc-1:0]                  force_send;
    logic                              err;
    logic [NumVc-1:0][15:0]            stat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_link_vc_axis_rx #(
        .NumVc          (NumVc),
        .DataWidth      (DataWidth),
        .NumCredits     (NumCredits),
        .ForceSendThresh(2)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .axis_tvalid_i       (tvalid),
        .axis_tready_o       (tready),
        .axis_tdata_i        (tdata),
        .axis_tuser_i        (tuser),
        .vc_valid_o          (vc_valid),
        .vc_ready_i          (vc_ready),
        .vc_data_o           (vc_data),
        .credits_rcvd_valid_o(crd_valid),
        .credits_rcvd_o      (crd_rcvd),
        .credits_pending_o   (crd_pend),
        .credits_taken_i     (taken),
        .force_send_o        (force_send),
        .err_o               (err),
        .stat_flits_o        (stat)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  vc;
        logic [31:0] payload;
        logic        dv;
        logic [2:0]  cr;
        logic [2:0]  rdy;
        logic [2:0]  tk;
        logic        e_tready;
        logic [2:0]  e_vcv;
        logic [2:0]  e_crdv;
        logic [2:0]  e_crd0;
        logic [2:0]  e_pend0;
        logic [2:0]  e_force;
        logic        e_err;
        logic [1:0]  e_dvc;   // VC whose head data is checked; 3 = none
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        tvalid   = 1'b0;
        tdata    = '0;
        tuser    = '0;
        vc_ready = '0;
        taken    = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        tvalid   = v.valid;
        tdata    = {v.vc, v.payload};
        tuser    = {v.dv, v.cr};
        vc_ready = v.rdy;
        taken    = v.tk;
        #1;
        check($sformatf("v%0d_tready", idx), 32'(tready), 32'(v.e_tready));
        @(posedge clk);
        #1;
        check($sformatf("v%0d_vc_valid", idx), 32'(vc_valid), 32'(v.e_vcv));
        check($sformatf("v%0d_crd_valid", idx), 32'(crd_valid), 32'(v.e_crdv));
        check($sformatf("v%0d_crd0", idx), 32'(crd_rcvd[0]), 32'(v.e_crd0));
        check($sformatf("v%0d_pend0", idx), 32'(crd_pend[0]), 32'(v.e_pend0));
        check($sformatf("v%0d_force", idx), 32'(force_send), 32'(v.e_force));
        check($sformatf("v%0d_err", idx), 32'(err), 32'(v.e_err));
        if (v.e_dvc != 2'd3) begin
            check($sformatf("v%0d_data", idx), vc_data[v.e_dvc], v.e_data);
        end
`ifndef SERIAL_LINK_VC_RX_STATS_EN
        check($sformatf("v%0d_stat", idx), 32'(stat), 32'd0);
`endif
    endtask

    initial begin
        // Fields: valid vc payload dv cr rdy tk | tready vcv crdv crd0 pend0 force err dvc data
        vecs.push_back('{1'b1, 2'd1, 32'hA5A5A5A5, 1'b1, 3'd0, 3'b000, 3'b000,
                         1'b1, 3'b010, 3'b000, 3'd0, 3'd0, 3'b000, 1'b0, 2'd1, 32'hA5A5A5A5});
        // Credits-only packet to VC0
        vecs.push_back('{1'b1, 2'd0, 32'h0, 1'b0, 3'd3, 3'b000, 3'b000,
                         1'b1, 3'b010, 3'b001, 3'd3, 3'd0, 3'b000, 1'b0, 2'd3, 32'h0});
        // Pulse gone
        vecs.push_back('{1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 3'b000, 3'b000,
                         1'b1, 3'b010, 3'b000, 3'd0, 3'd0, 3'b000, 1'b0, 2'd1, 32'hA5A5A5A5});
        // Fill VC0 with six flits
        for (int i = 0; i < 6; i++) begin
            vecs.push_back('{1'b1, 2'd0, 32'h100 + 32'(i), 1'b1, 3'd0, 3'b000, 3'b000,
                             1'b1, 3'b011, 3'b000, 3'd0, 3'd0, 3'b000, 1'b0, 2'd0, 32'h100});
        end
        // Seventh flit stalls
        vecs.push_back('{1'b1, 2'd0, 32'h106, 1'b1, 3'd0, 3'b000, 3'b000,
                         1'b0, 3'b011, 3'b000, 3'd0, 3'd0, 3'b000, 1'b0, 2'd0, 32'h100});
        // VC1 still accepts
        vecs.push_back('{1'b1, 2'd1, 32'hB1, 1'b1, 3'd0, 3'b000, 3'b000,
                         1'b1, 3'b011, 3'b000, 3'd0, 3'd0, 3'b000, 1'b0, 2'd1, 32'hA5A5A5A5});
        // Two pops from VC0, then pop together with a take
        vecs.push_back('{1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 3'b001, 3'b000,
                         1'b1, 3'b011, 3'b000, 3'd0, 3'd1, 3'b000, 1'b0, 2'd0, 32'h101});
        vecs.push_back('{1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 3'b001, 3'b000,
                         1'b1, 3'b011, 3'b000, 3'd0, 3'd2, 3'b001, 1'b0, 2'd0, 32'h102});
        vecs.push_back('{1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 3'b001, 3'b001,
                         1'b1, 3'b011, 3'b000, 3'd0, 3'd1, 3'b000, 1'b0, 2'd0, 32'h103});
        // Refill VC0 to full
        for (int i = 0; i < 3; i++) begin
            vecs.push_back('{1'b1, 2'd0, 32'h106 + 32'(i), 1'b1, 3'd0, 3'b000, 3'b000,
                             1'b1, 3'b011, 3'b000, 3'd0, 3'd1, 3'b000, 1'b0, 2'd0, 32'h103});
        end
        // Full with same-cycle pop: still not ready
        vecs.push_back('{1'b1, 2'd0, 32'h109, 1'b1, 3'd0, 3'b001, 3'b000,
                         1'b0, 3'b011, 3'b000, 3'd0, 3'd2, 3'b001, 1'b0, 2'd0, 32'h104});
        vecs.push_back('{1'b1, 2'd0, 32'h109, 1'b1, 3'd0, 3'b000, 3'b000,
                         1'b1, 3'b011, 3'b000, 3'd0, 3'd2, 3'b001, 1'b0, 2'd0, 32'h104});
        // Invalid VC index: accepted, dropped, no credit pulse, error
        vecs.push_back('{1'b1, 2'd3, 32'hDEAD, 1'b1, 3'd2, 3'b000, 3'b000,
                         1'b1, 3'b011, 3'b000, 3'd0, 3'd2, 3'b001, 1'b1, 2'd0, 32'h104});

        drive_idle();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vc_valid", 32'(vc_valid), 32'd0);
        check("rst_crd_valid", 32'(crd_valid), 32'd0);
        check("rst_crd_rcvd", 32'(crd_rcvd), 32'd0);
        check("rst_pending", 32'(crd_pend), 32'd0);
        check("rst_force", 32'(force_send), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stat", 32'(stat), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            run_vec(i, vecs[i]);
        end

        // Reset during a transfer clears queues, pending counts and the error
        @(negedge clk);
        rst_ni   = 1'b0;
        tvalid   = 1'b1;
        tdata    = {2'd2, 32'h55};
        tuser    = {1'b1, 3'd1};
        vc_ready = '0;
        taken    = '0;
        @(posedge clk);
        #1;
        check("midrst_vc_valid", 32'(vc_valid), 32'd0);
        check("midrst_pending", 32'(crd_pend), 32'd0);
        check("midrst_crd_valid", 32'(crd_valid), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        @(negedge clk);
        drive_idle();
        rst_ni = 1'b1;

        // Seven streamed pops on VC0 overflow the pending counter
        vc_ready = 3'b001;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            tvalid = 1'b1;
            tdata  = {2'd0, 32'h200 + 32'(i)};
            tuser  = {1'b1, 3'd0};
            #1;
            check($sformatf("ovf_tready%0d", i), 32'(tready), 32'd1);
            if (i > 0) begin
                check($sformatf("ovf_order%0d", i), vc_data[0], 32'h200 + 32'(i - 1));
            end
        end
        @(negedge clk);
        tvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("ovf_pend0_sat", 32'(crd_pend[0]), 32'd6);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_vc_valid", 32'(vc_valid), 32'd0);
        check("ovf_force", 32'(force_send), 32'b001);
`ifdef SERIAL_LINK_VC_RX_STATS_EN
        check("stat_after_ovf", 32'(stat[0]), 32'd7);
`else
        check("stat_tied_zero", 32'(stat), 32'd0);
`endif

`ifdef SERIAL_LINK_VC_RX_STATS_EN
        // Counter wrap: 0x10000 pushes return to zero, one more gives 1
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni   = 1'b1;
        vc_ready = 3'b001;
        tvalid   = 1'b1;
        tdata    = {2'd0, 32'h77};
        tuser    = {1'b1, 3'd0};
        repeat (65536) @(posedge clk);
        #1;
        tvalid = 1'b0;
        check("stat_wrap", 32'(stat[0]), 32'd0);
        @(negedge clk);
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        check("stat_after_wrap", 32'(stat[0]), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
